// File: rtl/dac_ad56x3_spi_sink.sv
// Avalon-ST sink serialising one DAC sample per handshake as a 24-bit
// SPI write frame to an AD56x3 dual DAC (syncN/sclk/din).
// Ports: clk, reset (async, high); asiValid/asiChannel/asiData/asiRdy
// sink; syncN, sclk (idle high), din (MSB first) SPI; busy status.
// Option: define DRV_AD56X3_INTREF_EN to send an internal-reference
// enable frame (24'h380001) after every reset before accepting data.
module dac_ad56x3_spi_sink #(
  parameter int DATA_WIDTH = 14,
  parameter int SCLK_DIV = 2,
  parameter int SYNC_HIGH_CYCLES = 2,
  parameter logic [2:0] CMD = 3'b011
) (
  input  logic clk,
  input  logic reset,
  input  logic asiValid,
  input  logic asiChannel,
  input  logic [DATA_WIDTH-1:0] asiData,
  output logic asiRdy,
  output logic syncN,
  output logic sclk,
  output logic din,
  output logic busy
);

  if (DATA_WIDTH < 12 || DATA_WIDTH > 16) begin : g_bad_dw
    $error("DATA_WIDTH must be 12..16");
  end
  if (SCLK_DIV < 1) begin : g_bad_div
    $error("SCLK_DIV must be >= 1");
  end
  if (SYNC_HIGH_CYCLES < 1) begin : g_bad_gap
    $error("SYNC_HIGH_CYCLES must be >= 1");
  end

  localparam int DW = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam int GW =
    (SYNC_HIGH_CYCLES > 1) ? $clog2(SYNC_HIGH_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_FALL = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_HIGH_CYCLES - 1);

`ifdef DRV_AD56X3_INTREF_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, INIT} state_t;
  localparam state_t RST_STATE = INIT;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_n;
  logic [23:0] shreg, shreg_n;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] div_cnt, div_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic rdy_n, sync_n, sclk_n, din_n, busy_n;
  logic [15:0] data16;
  logic [23:0] frame;

  // Sample is left-aligned in the 16-bit data field.
  assign data16 = 16'(asiData) << (16 - DATA_WIDTH);
  assign frame = {2'b00, CMD, 2'b00, asiChannel, data16};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
      shreg <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      asiRdy <= 1'b0;
      syncN <= 1'b1;
      sclk <= 1'b1;
      din <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      gap_cnt <= gap_cnt_n;
      asiRdy <= rdy_n;
      syncN <= sync_n;
      sclk <= sclk_n;
      din <= din_n;
      busy <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    gap_cnt_n = gap_cnt;
    rdy_n = asiRdy;
    sync_n = syncN;
    sclk_n = sclk;
    din_n = din;
    busy_n = busy;
    unique case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (asiValid && asiRdy) begin
          shreg_n = frame;
          din_n = frame[23];
          sync_n = 1'b0;
          sclk_n = 1'b1;
          rdy_n = 1'b0;
          busy_n = 1'b1;
          bit_cnt_n = '0;
          div_cnt_n = '0;
          state_n = SHIFT;
        end
      end
`ifdef DRV_AD56X3_INTREF_EN
      INIT: begin
        shreg_n = 24'h380001;
        din_n = 1'b0;
        sync_n = 1'b0;
        sclk_n = 1'b1;
        rdy_n = 1'b0;
        busy_n = 1'b1;
        bit_cnt_n = '0;
        div_cnt_n = '0;
        state_n = SHIFT;
      end
`endif
      SHIFT: begin
        div_cnt_n = div_cnt + 1'b1;
        if (div_cnt == DIV_FALL) sclk_n = 1'b0;
        if (div_cnt == DIV_LAST) begin
          sclk_n = 1'b1;
          div_cnt_n = '0;
          if (bit_cnt == 5'd23) begin
            sync_n = 1'b1;
            din_n = 1'b0;
            gap_cnt_n = '0;
            state_n = GAP;
          end else begin
            shreg_n = {shreg[22:0], 1'b0};
            din_n = shreg[22];
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) begin
          rdy_n = 1'b1;
          busy_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = RST_STATE;
    endcase
  end

endmodule

// File: doc/dac_ad56x3_spi_sink.md
Name: dac_ad56x3_spi_sink

Overview:
- Avalon-ST sink that accepts one DAC sample per handshake (channel + data) and serialises it as a 24-bit SPI write frame to an AD56x3 dual DAC (SYNC_N, SCLK, DIN).
- Sits downstream of the saw/test generator or any Avalon-ST sample source.
- Its ready output paces the source: one frame per accepted word.

Parameters:
- DATA_WIDTH, 14, sample width; legal 12..16, elaboration error otherwise.
- SCLK_DIV, 2, clk cycles per SCLK half-period; minimum 1.
- SYNC_HIGH_CYCLES, 2, clk cycles SYNC_N stays high between frames; minimum 1.
- CMD, 3'b011, command field sent with every sample ("write to and update DAC n").

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- asiValid  in  1  Avalon-ST sink valid
- asiChannel  in  1  0 = DAC A, 1 = DAC B
- asiData  in  DATA_WIDTH  unsigned sample
- asiRdy  out  1  Avalon-ST sink ready
- syncN  out  1  SPI frame select, active low
- sclk  out  1  SPI clock; idle high; DAC samples DIN on the falling edge
- din  out  1  SPI serial data, MSB first
- busy  out  1  high while a frame or inter-frame gap is in progress

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- Reset values: asiRdy=0, syncN=1, sclk=1, din=0, busy=0. State goes to IDLE (or INIT, see Optional Feature). Internal counters and shift register are cleared.
- Reset asserted mid-frame aborts the frame immediately. syncN rising aborts the DAC write, so no partial update occurs.
- asiRdy is registered: it is 1 only in IDLE and never depends on asiValid. Acceptance happens on a clk edge where asiValid & asiRdy.
- Frame format, 24 bits, MSB first: [23:22]=00, [21:19]=CMD, [18:16]={2'b00, asiChannel}, [15:0]={asiData, (16-DATA_WIDTH) zeros}. Data is left-aligned.
- States: IDLE, SHIFT, GAP, plus INIT when the option is enabled.
- IDLE: on acceptance, load the shift register and set syncN<=0, sclk<=1, din<=frame[23], asiRdy<=0, busy<=1, bitCnt<=0, divCnt<=0. Go to SHIFT.
- SHIFT: divCnt counts 0..2*SCLK_DIV-1.
  - At divCnt==SCLK_DIV-1: sclk<=0 (DAC samples this bit).
  - At divCnt==2*SCLK_DIV-1: sclk<=1.
  - If bitCnt==23: syncN<=1, go to GAP.
  - Otherwise: shift, din<=next bit, bitCnt++.
- GAP: syncN=1, sclk=1, din=0. Hold for SYNC_HIGH_CYCLES cycles, then asiRdy<=1, busy<=0, go to IDLE.
- Timing: exactly 24 SCLK falling edges per frame, all with syncN=0. din is stable for SCLK_DIV cycles on each side of every falling edge.
- Throughput: asiRdy returns high 48*SCLK_DIV + SYNC_HIGH_CYCLES clk cycles after the accepting edge.
- asiValid and asiChannel/asiData are ignored outside IDLE. Data changes while asiRdy=0 have no effect.
- Back-to-back: if asiValid is held high, the next frame starts on the first cycle asiRdy=1. This gives an alternating-channel stream from a ping-pong source with no lost words.

Optional Feature:
- Macro DRV_AD56X3_INTREF_EN.
- Defined: after reset release, the state is INIT and asiRdy stays 0. One frame 24'h380001 (CMD=111, internal reference on) is sent with the same SHIFT timing, then GAP, then IDLE. Reset during INIT restarts INIT.
- Undefined: the INIT state is absent. After reset the block enters IDLE, and asiRdy=1 on the first clk edge after reset deasserts.

Test Plan:
- DATA_WIDTH=14, SCLK_DIV=2, send channel=0, data=14'h2ABC -> bits sampled on sclk falling edges = 24'h18AAF0; syncN low for exactly 96 clk; asiRdy high again 98 clk after acceptance.
- Send channel=1, data=14'h3FFF -> captured frame 24'h19FFFC; address bits 001.
- asiValid held high, source alternating A/B with an incrementing ramp for 20 words -> 20 frames, addresses alternate 000/001, data matches in order, gaps are exactly SYNC_HIGH_CYCLES.
- Assert reset at the 10th falling edge of a frame -> syncN=1, sclk=1, din=0 in the same cycle; the next frame after release is complete and correct.
- asiData changes every cycle while busy -> captured frame equals the value present at the acceptance edge.
- With DRV_AD56X3_INTREF_EN defined -> first frame after reset is 24'h380001 and asiRdy=0 until it completes. Without the macro -> asiRdy=1 one cycle after reset release.
